seg_scan_ctrl: RTL and testbench

Time-multiplexed seven-segment scan controller for the Nexys A7 eight-digit display. It sits directly upstream of the parameterised n-bit decoder. It generates the digit-select code and the decoder enable, and it drives the shared cathode pattern for the digit being shown. Display data is held in a shadow register, which is updated only at frame boundaries through a req/ack handshake.

---
 rtl/seg_scan_pkg.sv | 18 +
 rtl/hex7seg_lut.sv | 11 +
 rtl/seg_scan_ctrl.sv | 109 ++++++++++
 tb/tb_seg_scan_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Segment vectors are ordered {g,f,e,d,c,b,a} and are active-low.
package seg_scan_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Entry 15 is listed first so that HEX_SEG_TABLE[n] gives the pattern for nibble n.
  localparam logic [15:0][6:0] HEX_SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/hex7seg_lut.sv
// Combinational hex nibble to active-low seven-segment pattern lookup.
module hex7seg_lut
  import seg_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG_TABLE[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an eight-digit seven-segment display.
// Digit data lives in a shadow register that only reloads at the frame wrap,
// so a frame never shows a mix of old and new values.
// Optional decimal-point support is enabled by defining SEG_SCAN_CTRL_DP_EN.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int DATA_WIDTH   = 3,
  parameter int PRESCALE     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [4*(2**DATA_WIDTH)-1:0]   digits_in,
  input  logic [(2**DATA_WIDTH)-1:0]     mask_in,
  input  logic                           upd_req,
  output logic                           upd_ack,
  output logic [DATA_WIDTH-1:0]          sel_out,
  output logic                           sel_en,
  output logic [6:0]                     seg_out,
  output logic                           frame_tick
`ifdef SEG_SCAN_CTRL_DP_EN
  ,
  input  logic [(2**DATA_WIDTH)-1:0]     dp_in,
  output logic                           dp_out
`endif
);

  localparam int N  = 2**DATA_WIDTH;
  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0]         SLOT_LAST  = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]         BLANK_LAST = PW'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] IDX_LAST   = DATA_WIDTH'(N - 1);

  logic [PW-1:0]         pcnt, pcnt_nxt;
  logic [DATA_WIDTH-1:0] idx, idx_nxt;
  scan_state_t           state, state_nxt;
  logic [4*N-1:0]        shadow_digits, shadow_digits_nxt;
  logic [N-1:0]          shadow_mask, shadow_mask_nxt;
  logic                  slot_end, wrap, load, lit_nxt;
  logic [3:0]            nibble_nxt;
  logic [6:0]            seg_lut;
`ifdef SEG_SCAN_CTRL_DP_EN
  logic [N-1:0]          shadow_dp, shadow_dp_nxt;
`endif

  // Next-state decode; outputs are registered from these next values so they line up with the state registers.
  always_comb begin
    slot_end          = (pcnt == SLOT_LAST);
    wrap              = slot_end && (idx == IDX_LAST);
    load              = wrap && upd_req;
    pcnt_nxt          = slot_end ? '0 : pcnt + PW'(1);
    idx_nxt           = slot_end ? idx + DATA_WIDTH'(1) : idx;
    state_nxt         = state;
    case (state)
      BLANK:   if ((BLANK_CYCLES == 0) || (pcnt == BLANK_LAST)) state_nxt = SHOW;
      SHOW:    if (slot_end && (BLANK_CYCLES != 0)) state_nxt = BLANK;
      default: state_nxt = BLANK;
    endcase
    shadow_digits_nxt = load ? digits_in : shadow_digits;
    shadow_mask_nxt   = load ? mask_in : shadow_mask;
`ifdef SEG_SCAN_CTRL_DP_EN
    shadow_dp_nxt     = load ? dp_in : shadow_dp;
`endif
    nibble_nxt        = shadow_digits_nxt[idx_nxt*4 +: 4];
    lit_nxt           = (state_nxt == SHOW) && shadow_mask_nxt[idx_nxt];
  end

  hex7seg_lut u_lut (
    .nibble (nibble_nxt),
    .seg    (seg_lut)
  );

  // Scan state, shadow registers and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt          <= '0;
      idx           <= '0;
      state         <= BLANK;
      shadow_digits <= '0;
      shadow_mask   <= '0;
      sel_out       <= '0;
      sel_en        <= 1'b0;
      seg_out       <= SEG_OFF;
      upd_ack       <= 1'b0;
      frame_tick    <= 1'b0;
`ifdef SEG_SCAN_CTRL_DP_EN
      shadow_dp     <= '0;
      dp_out        <= 1'b1;
`endif
    end else begin
      pcnt          <= pcnt_nxt;
      idx           <= idx_nxt;
      state         <= state_nxt;
      shadow_digits <= shadow_digits_nxt;
      shadow_mask   <= shadow_mask_nxt;
      sel_out       <= idx_nxt;
      sel_en        <= lit_nxt;
      seg_out       <= lit_nxt ? seg_lut : SEG_OFF;
      upd_ack       <= load;
      frame_tick    <= wrap;
`ifdef SEG_SCAN_CTRL_DP_EN
      shadow_dp     <= shadow_dp_nxt;
      dp_out        <= ~(lit_nxt && shadow_dp_nxt[idx_nxt]);
`endif
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl with four digits and 8-cycle slots.
// dut uses two blanking cycles per slot; dut0 runs the same stimulus with blanking disabled.
`timescale 1ns/1ps
module tb_seg_scan_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] digits_in;
  logic [3:0]  mask_in;
  logic        upd_req;

  logic        upd_ack, sel_en, frame_tick;
  logic [1:0]  sel_out;
  logic [6:0]  seg_out;
  logic        upd_ack0, sel_en0, frame_tick0;
  logic [1:0]  sel_out0;
  logic [6:0]  seg_out0;
`ifdef SEG_SCAN_CTRL_DP_EN
  logic        dp_out, dp_out0;
`endif

  int          cycle;
  int          checks;
  int          errors;
  logic [15:0] exp_digits;
  logic [3:0]  exp_mask;
  logic        exp_ack;

  seg_scan_ctrl #(.DATA_WIDTH(2), .PRESCALE(8), .BLANK_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .digits_in  (digits_in),
    .mask_in    (mask_in),
    .upd_req    (upd_req),
    .upd_ack    (upd_ack),
    .sel_out    (sel_out),
    .sel_en     (sel_en),
    .seg_out    (seg_out),
    .frame_tick (frame_tick)
`ifdef SEG_SCAN_CTRL_DP_EN
    ,
    .dp_in      (4'h0),
    .dp_out     (dp_out)
`endif
  );

  seg_scan_ctrl #(.DATA_WIDTH(2), .PRESCALE(8), .BLANK_CYCLES(0)) dut0 (
    .clk        (clk),
    .rst        (rst),
    .digits_in  (digits_in),
    .mask_in    (mask_in),
    .upd_req    (upd_req),
    .upd_ack    (upd_ack0),
    .sel_out    (sel_out0),
    .sel_en     (sel_en0),
    .seg_out    (seg_out0),
    .frame_tick (frame_tick0)
`ifdef SEG_SCAN_CTRL_DP_EN
    ,
    .dp_in      (4'h0),
    .dp_out     (dp_out0)
`endif
  );

  // 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hand-entered active-low {g,f,e,d,c,b,a} patterns.
  function automatic logic [6:0] expSeg(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cycle, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] m, input logic req);
    digits_in = d;
    mask_in   = m;
    upd_req   = req;
  endtask

  task automatic checkResetValues();
    checkOutput("rst_sel_out", sel_out, 0);
    checkOutput("rst_sel_en", sel_en, 0);
    checkOutput("rst_seg_out", seg_out, 7'h7F);
    checkOutput("rst_upd_ack", upd_ack, 0);
    checkOutput("rst_frame_tick", frame_tick, 0);
    checkOutput("rst_sel_out0", sel_out0, 0);
    checkOutput("rst_sel_en0", sel_en0, 0);
    checkOutput("rst_seg_out0", seg_out0, 7'h7F);
  endtask

  // Advance n cycles; cycle k after reset release sits in slot (k/8)%4 at prescale k%8.
  task automatic checkCycles(input int n);
    int         idx, pc;
    logic       lit;
    logic [3:0] nib;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cycle++;
      idx = (cycle / 8) % 4;
      pc  = cycle % 8;
      lit = exp_mask[idx];
      nib = exp_digits[idx*4 +: 4];
      checkOutput("sel_out", sel_out, idx);
      checkOutput("sel_en", sel_en, (pc >= 2) && lit);
      checkOutput("seg_out", seg_out, ((pc >= 2) && lit) ? expSeg(nib) : 7'h7F);
      checkOutput("frame_tick", frame_tick, (cycle % 32 == 0) ? 1 : 0);
      checkOutput("upd_ack", upd_ack, exp_ack);
      checkOutput("sel_out0", sel_out0, idx);
      checkOutput("sel_en0", sel_en0, lit);
      checkOutput("seg_out0", seg_out0, lit ? expSeg(nib) : 7'h7F);
      checkOutput("frame_tick0", frame_tick0, (cycle % 32 == 0) ? 1 : 0);
      checkOutput("upd_ack0", upd_ack0, exp_ack);
    end
  endtask

  // Hold a request until the wrap 32-cycle boundary that is n+1 cycles away, expecting the load there.
  task automatic loadAtWrap(input int n, input logic [15:0] d, input logic [3:0] m);
    applyStimulus(d, m, 1'b1);
    checkCycles(n);
    exp_digits = d;
    exp_mask   = m;
    exp_ack    = 1'b1;
    checkCycles(1);
    applyStimulus(d, m, 1'b0);
    exp_ack    = 1'b0;
  endtask

  // Directed scenarios run back to back on one timeline.
  initial begin
    checks     = 0;
    errors     = 0;
    cycle      = 0;
    exp_digits = '0;
    exp_mask   = '0;
    exp_ack    = 1'b0;
    rst        = 1'b1;
    applyStimulus(16'h0000, 4'h0, 1'b0);
    @(negedge clk);
    checkResetValues();
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] idle frame after reset");
    checkCycles(32);

    $display("[TB] load 3210 with all digits lit");
    loadAtWrap(31, 16'h3210, 4'hF);
    checkCycles(32);

    $display("[TB] load 7E9B with mask 0101");
    loadAtWrap(31, 16'h7E9B, 4'b0101);
    checkCycles(32);

    $display("[TB] short request that misses the wrap");
    checkCycles(10);
    applyStimulus(16'hFFFF, 4'hF, 1'b1);
    checkCycles(3);
    applyStimulus(16'hFFFF, 4'hF, 1'b0);
    checkCycles(51);

    $display("[TB] reset during digit 2 show phase");
    checkCycles(22);
    checkOutput("pre_rst_sel_out", sel_out, 2);
    checkOutput("pre_rst_sel_en", sel_en, 1);
    #2 rst = 1'b1;
    #1 checkResetValues();
    @(negedge clk);
    @(negedge clk);
    rst        = 1'b0;
    cycle      = 0;
    exp_digits = '0;
    exp_mask   = '0;
    checkCycles(8);
    loadAtWrap(23, 16'h4D61, 4'hF);
    checkCycles(32);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
